// File: rtl/arbitrated_mem_mux_if.sv
// Requester-side and memory-side signals of the arbitrated memory mux.
// The mux connects through the slave modport. The requesters, arbiter and memory connect through the master modport.
interface arbitrated_mem_mux_if #(
    parameter int unsigned NUM_PORTS     = 4,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 32
);
    localparam int unsigned GW = $clog2(NUM_PORTS);

    logic [GW-1:0]                      grant;
    logic                               grant_valid;
    logic [NUM_PORTS-1:0]               port_read;
    logic [NUM_PORTS-1:0]               port_write;
    logic [NUM_PORTS*ADDRESS_WIDTH-1:0] port_address;
    logic [NUM_PORTS*DATA_WIDTH-1:0]    port_data_in;
    logic [NUM_PORTS-1:0]               port_resp_valid;
    logic [DATA_WIDTH-1:0]              port_data_out;
    logic                               mem_read;
    logic                               mem_write;
    logic [ADDRESS_WIDTH-1:0]           mem_address;
    logic [DATA_WIDTH-1:0]              mem_data_out;
    logic                               mem_ready;
    logic                               mem_resp_valid;
    logic [DATA_WIDTH-1:0]              mem_data_in;
    logic                               stray_resp;

    modport slave (
        input  grant, grant_valid, port_read, port_write, port_address, port_data_in,
        input  mem_ready, mem_resp_valid, mem_data_in,
        output port_resp_valid, port_data_out, mem_read, mem_write, mem_address,
        output mem_data_out, stray_resp
    );

    modport master (
        output grant, grant_valid, port_read, port_write, port_address, port_data_in,
        output mem_ready, mem_resp_valid, mem_data_in,
        input  port_resp_valid, port_data_out, mem_read, mem_write, mem_address,
        input  mem_data_out, stray_resp
    );
endinterface

// File: rtl/arbitrated_mem_mux.sv
// Captures the arbiter-granted port's request and issues it on the shared memory interface.
// It routes the response back to the owning port. Only one transaction is outstanding at a time.
module arbitrated_mem_mux #(
    parameter int unsigned NUM_PORTS     = 4,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 32
) (
    input logic                  clock,
    input logic                  reset,
    arbitrated_mem_mux_if.slave  bus
);
    localparam int unsigned GW = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                   state_q;
    logic [GW-1:0]            owner_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [DATA_WIDTH-1:0]    rdata_q;
    logic                     mem_read_q;
    logic                     mem_write_q;
    logic [NUM_PORTS-1:0]     resp_valid_q;
    logic                     stray_q;

    logic                     sel_hit;
    logic                     sel_read;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]    sel_data;

    // Index match over the real ports only, so an out-of-range grant selects nothing
    always_comb begin
        sel_hit  = 1'b0;
        sel_read = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (bus.grant == GW'(i)) begin
                sel_hit  = bus.port_read[i] | bus.port_write[i];
                sel_read = bus.port_read[i];
                sel_addr = bus.port_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                sel_data = bus.port_data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            owner_q      <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            resp_valid_q <= '0;
            stray_q      <= 1'b0;
        end else begin
            stray_q      <= 1'b0;
            resp_valid_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (bus.mem_resp_valid) stray_q <= 1'b1;
                    if (bus.grant_valid && sel_hit) begin
                        owner_q     <= bus.grant;
                        addr_q      <= sel_addr;
                        wdata_q     <= sel_data;
                        mem_read_q  <= sel_read;
                        mem_write_q <= ~sel_read;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.mem_ready) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        // Accept and response in the same cycle skip WAIT entirely
                        if (bus.mem_resp_valid) begin
                            rdata_q      <= bus.mem_data_in;
                            resp_valid_q <= NUM_PORTS'(1) << owner_q;
                            state_q      <= S_DONE;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end else if (bus.mem_resp_valid) begin
                        stray_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        rdata_q      <= bus.mem_data_in;
                        resp_valid_q <= NUM_PORTS'(1) << owner_q;
                        state_q      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.mem_resp_valid) stray_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_read        = mem_read_q;
    assign bus.mem_write       = mem_write_q;
    assign bus.mem_address     = addr_q;
    assign bus.mem_data_out    = wdata_q;
    assign bus.port_resp_valid = resp_valid_q;
    assign bus.port_data_out   = rdata_q;
    assign bus.stray_resp      = stray_q;
endmodule
